// File: rtl/fm_guard_packer.sv
// fm_guard_packer: packs write-back FM bytes and guard maps into buffer words with per-layer counts.
module fm_guard_lane #(
  parameter int W = 8,
  parameter int N = 8,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            run,
  input  logic            last,
  input  logic [AW-1:0]   base_i,
  input  logic [W-1:0]    d,
  input  logic            valid,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [W*N-1:0]  wr_data,
  output logic [AW:0]     words,
  output logic            ovf
);
  localparam int LW = $clog2(N);
  logic [LW-1:0]  lane;
  logic [W*N-1:0] acc, word;
  logic [AW-1:0]  base;
  logic [AW+1:0]  sum;
  logic           take, full, flush, write;
  assign take  = run && valid;
  assign full  = take && lane == LW'(N - 1);
  // a partial word is flushed on the last_i edge itself so it lands before DONE
  assign flush = run && last && !full && (take || lane != '0);
  assign write = full || flush;
  assign sum   = {2'b00, base} + {1'b0, words};
  always_comb begin
    word = acc;
    if (take) word[lane*W +: W] = d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lane    <= '0;
      acc     <= '0;
      base    <= '0;
      words   <= '0;
      ovf     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        base  <= base_i;
        lane  <= '0;
        acc   <= '0;
        words <= '0;
        ovf   <= 1'b0;
      end else begin
        if (take) begin
          acc  <= word;
          lane <= lane + LW'(1);
        end
        if (write) begin
          wr_en   <= 1'b1;
          wr_addr <= sum[AW-1:0];
          wr_data <= word;
          words   <= words + (AW+1)'(1);
          acc     <= '0;
          lane    <= '0;
          ovf     <= ovf | (|sum[AW+1:AW]);
        end
      end
    end
  end
endmodule

module fm_guard_packer #(
  parameter int FM_WORD_BYTES = 8,
  parameter int GUARD_GROUPS  = 8,
  parameter int FM_ADDR_W     = 10,
  parameter int GUARD_ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_valid,
  output logic                      ctrl_ready,
  output logic                      ctrl_finish,
  input  logic [FM_ADDR_W-1:0]      fm_base_addr_i,
  input  logic [GUARD_ADDR_W-1:0]   guard_base_addr_i,
  input  logic [7:0]                data_i,
  input  logic                      data_i_valid,
  input  logic [5:0]                guard_i,
  input  logic                      guard_i_valid,
  input  logic                      last_i,
  output logic                      fm_wr_en,
  output logic [FM_ADDR_W-1:0]      fm_wr_addr,
  output logic [8*FM_WORD_BYTES-1:0] fm_wr_data,
  output logic                      guard_wr_en,
  output logic [GUARD_ADDR_W-1:0]   guard_wr_addr,
  output logic [6*GUARD_GROUPS-1:0] guard_wr_data,
  output logic [FM_ADDR_W:0]        fm_words_o,
  output logic [GUARD_ADDR_W:0]     guard_words_o,
  output logic                      overflow_o
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic start, run, fm_ovf, guard_ovf;
  assign start       = state == IDLE && ctrl_valid;
  assign run         = state == RUN;
  assign ctrl_ready  = state == IDLE;
  assign ctrl_finish = state == DONE;
  assign overflow_o  = fm_ovf | guard_ovf;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ctrl_valid ? RUN : IDLE;
      RUN:     state_nx = last_i ? FLUSH : RUN;
      FLUSH:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  fm_guard_lane #(.W(8), .N(FM_WORD_BYTES), .AW(FM_ADDR_W)) u_fm (
    .clk(clk), .rst(rst), .start(start), .run(run), .last(last_i),
    .base_i(fm_base_addr_i), .d(data_i), .valid(data_i_valid),
    .wr_en(fm_wr_en), .wr_addr(fm_wr_addr), .wr_data(fm_wr_data),
    .words(fm_words_o), .ovf(fm_ovf)
  );
  fm_guard_lane #(.W(6), .N(GUARD_GROUPS), .AW(GUARD_ADDR_W)) u_guard (
    .clk(clk), .rst(rst), .start(start), .run(run), .last(last_i),
    .base_i(guard_base_addr_i), .d(guard_i), .valid(guard_i_valid),
    .wr_en(guard_wr_en), .wr_addr(guard_wr_addr), .wr_data(guard_wr_data),
    .words(guard_words_o), .ovf(guard_ovf)
  );
endmodule
